// File: rtl/vga_timing_out.sv
// VGA raster timing generator with a one-stage colour/sync output register.
// Latency: col/row are combinational from the counters; R/G/B, rdn, HS, VS, frame_start and vblank lag them by 1 clk.
// Backpressure: none; the raster free-runs and Din is sampled every cycle.
//
// Ports:
//   clk, rst          pixel clock, asynchronous active-high reset
//   Din[11:0]         colour {R,G,B} for the pixel addressed by col/row this cycle
//   col, row          coordinate being requested (0 outside the visible area)
//   R, G, B           registered colour to the DAC (0 during blanking)
//   HS, VS            registered active-low syncs
//   rdn               registered active-low "visible pixel on R/G/B"
//   frame_start       one-cycle pulse following the (0,0) counter state
//   vblank            registered "line counter outside visible lines"
module vga_timing_out #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] Din,
    output logic [9:0]  col,
    output logic [8:0]  row,
    output logic [3:0]  R,
    output logic [3:0]  G,
    output logic [3:0]  B,
    output logic        HS,
    output logic        VS,
    output logic        rdn,
    output logic        frame_start,
    output logic        vblank
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    // Raster counters
    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;

    // Output stage
    logic [11:0] rgb_q, rgb_d;
    logic        vis_q, vis_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        fs_q, fs_d;
    logic        vblank_q, vblank_d;

    logic h_vis;
    logic v_vis;
    logic h_wrap;

    always_comb begin
        h_vis  = (h_cnt_q < H_VIS);
        v_vis  = (v_cnt_q < V_VIS);
        h_wrap = (h_cnt_q == H_LAST);

        h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;

        // The line counter moves only on the pixel-counter wrap, so the
        // last line rolls over in the same cycle as the last pixel.
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        end

        col = h_vis ? h_cnt_q : 10'd0;
        row = v_vis ? v_cnt_q[8:0] : 9'd0;

        vis_d    = h_vis && v_vis;
        // Blanking-period Din is squashed here so it can never reach the DAC.
        rgb_d    = vis_d ? Din : 12'h000;
        // Both syncs are decoded from the same counter state and registered
        // together, so VS edges stay aligned to HS-delayed line boundaries.
        hs_d     = !((h_cnt_q >= H_SYNC_START) && (h_cnt_q < H_SYNC_END));
        vs_d     = !((v_cnt_q >= V_SYNC_START) && (v_cnt_q < V_SYNC_END));
        fs_d     = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
        vblank_d = !v_vis;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q  <= 10'd0;
            v_cnt_q  <= 10'd0;
            rgb_q    <= 12'h000;
            vis_q    <= 1'b0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            fs_q     <= 1'b0;
            vblank_q <= 1'b0;
        end else begin
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            rgb_q    <= rgb_d;
            vis_q    <= vis_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            fs_q     <= fs_d;
            vblank_q <= vblank_d;
        end
    end

    assign R           = rgb_q[11:8];
    assign G           = rgb_q[7:4];
    assign B           = rgb_q[3:0];
    assign rdn         = ~vis_q;
    assign HS          = hs_q;
    assign VS          = vs_q;
    assign frame_start = fs_q;
    assign vblank      = vblank_q;

endmodule

// File: tb/tb_vga_timing_out.sv
// Self-checking bench for vga_timing_out using a reduced raster so several
// whole frames fit in a short run: 16+4+6+6 = 32 pixels, 12+3+2+4 = 21 lines.
module tb_vga_timing_out;

    localparam int HV = 16, HF = 4, HSW = 6, HB = 6;
    localparam int VV = 12, VF = 3, VSW = 2, VB = 4;
    localparam int HT = HV + HF + HSW + HB;   // 32
    localparam int VT = VV + VF + VSW + VB;   // 21
    localparam int FRAME = HT * VT;           // 672

    logic        clk;
    logic        rst;
    logic [11:0] Din;
    logic [9:0]  col;
    logic [8:0]  row;
    logic [3:0]  R, G, B;
    logic        HS, VS, rdn, frame_start, vblank;

    vga_timing_out #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB)
    ) dut (
        .clk(clk), .rst(rst), .Din(Din),
        .col(col), .row(row), .R(R), .G(G), .B(B),
        .HS(HS), .VS(VS), .rdn(rdn),
        .frame_start(frame_start), .vblank(vblank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          k      = 0;      // clock edges since reset release
    logic [11:0] dprev  = 12'h000;

    // Observation vector: {col, row, rgb, rdn, HS, VS, frame_start, vblank}
    function automatic logic [37:0] pack(input logic [9:0] c, input logic [8:0] r,
                                         input logic [11:0] rgb, input logic n,
                                         input logic h, input logic v,
                                         input logic f, input logic b);
        return {c, r, rgb, n, h, v, f, b};
    endfunction

    function automatic logic [37:0] observe();
        return pack(col, row, {R, G, B}, rdn, HS, VS, frame_start, vblank);
    endfunction

    // Reference: after k edges from reset release the raster sits at pixel
    // k mod FRAME, and the registered outputs describe pixel k-1.
    function automatic logic [37:0] model(input int kk, input logic [11:0] dp);
        int p, hp, vp, hk, vk;
        logic vis;
        hk = kk % HT;
        vk = (kk / HT) % VT;
        if (kk == 0)
            return pack(10'd0, 9'd0, 12'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        p   = kk - 1;
        hp  = p % HT;
        vp  = (p / HT) % VT;
        vis = (hp < HV) && (vp < VV);
        return pack((hk < HV) ? 10'(hk) : 10'd0,
                    (vk < VV) ? 9'(vk) : 9'd0,
                    vis ? dp : 12'h000,
                    !vis,
                    !(hp >= HV + HF && hp < HV + HF + HSW),
                    !(vp >= VV + VF && vp < VV + VF + VSW),
                    (p % FRAME) == 0,
                    vp >= VV);
    endfunction

    task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got col=%0d row=%0d rgb=%h rdn=%b hs=%b vs=%b fs=%b vb=%b want col=%0d row=%0d rgb=%h rdn=%b hs=%b vs=%b fs=%b vb=%b",
                     name, k, act[37:28], act[27:19], act[18:7], act[6], act[5], act[4], act[3], act[2],
                     exp[37:28], exp[27:19], exp[18:7], exp[6], exp[5], exp[4], exp[3], exp[2]);
        end
    endtask

    // Drive d for one clock, then land on the following negedge to sample.
    task automatic step(input logic [11:0] d);
        Din = d;
        @(posedge clk);
        k++;
        dprev = d;
        @(negedge clk);
    endtask

    task automatic run_model(input int n);
        for (int i = 0; i < n; i++) begin
            step(12'($urandom()));
            check("model", observe(), model(k, dprev));
        end
    endtask

    typedef struct {
        int          kk;
        logic [11:0] din;
        logic [37:0] exp;
    } vec_t;

    vec_t tbl[12];

    initial begin
        // k, Din in the cycle before edge k, expected outputs after edge k
        tbl[0]  = '{1,   12'hABC, pack(10'd1, 9'd0, 12'hABC, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0)};
        tbl[1]  = '{2,   12'h123, pack(10'd2, 9'd0, 12'h123, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)};
        tbl[2]  = '{17,  12'hFFF, pack(10'd0, 9'd0, 12'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0)};
        tbl[3]  = '{21,  12'hFFF, pack(10'd0, 9'd0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0)};
        tbl[4]  = '{26,  12'hFFF, pack(10'd0, 9'd0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0)};
        tbl[5]  = '{27,  12'hFFF, pack(10'd0, 9'd0, 12'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0)};
        tbl[6]  = '{33,  12'h5A5, pack(10'd1, 9'd1, 12'h5A5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)};
        tbl[7]  = '{385, 12'hFFF, pack(10'd1, 9'd0, 12'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1)};
        tbl[8]  = '{481, 12'hFFF, pack(10'd1, 9'd0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1)};
        tbl[9]  = '{545, 12'hFFF, pack(10'd1, 9'd0, 12'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1)};
        tbl[10] = '{672, 12'hFFF, pack(10'd0, 9'd0, 12'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1)};
        tbl[11] = '{673, 12'h0F0, pack(10'd1, 9'd0, 12'h0F0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0)};

        rst = 1'b1;
        Din = 12'h000;
        repeat (3) @(negedge clk);
        check("reset_hold", observe(), model(0, 12'h000));
        rst = 1'b0;
        k   = 0;
        check("release", observe(), model(0, 12'h000));

        // Directed points: pixel, porch, sync edges, line/frame wraps.
        // Filler Din is all-ones so any blanking leak would show.
        for (int i = 0; i < 12; i++) begin
            while (k < tbl[i].kk - 1) step(12'hFFF);
            step(tbl[i].din);
            check($sformatf("vec%0d", i), observe(), tbl[i].exp);
        end

        // Randomised colour over more than two full frames.
        run_model(2 * FRAME + 40);

        // Asynchronous reset mid-frame, asserted between clock edges.
        while ((k % FRAME) != 5 * HT + 9) step(12'($urandom()));
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("async_rst", observe(), model(0, 12'h000));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_held", observe(), model(0, 12'h000));
        end
        rst = 1'b0;
        k   = 0;
        check("rst_release", observe(), model(0, 12'h000));

        // Frame must restart cleanly from (0,0).
        run_model(FRAME + 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_out.md
VGA_TIMING_OUT -- requirements
Module: vga_timing_out

Interface
REQ-001 Parameter H_VISIBLE, default 640: visible pixels per line.
REQ-002 Parameter H_FRONT, default 16: horizontal front porch, in pixels.
REQ-003 Parameter H_SYNC, default 96: horizontal sync width, in pixels.
REQ-004 Parameter H_BACK, default 48: horizontal back porch, in pixels.
REQ-005 Parameter V_VISIBLE, default 480: visible lines per frame.
REQ-006 Parameter V_FRONT, default 10: vertical front porch, in lines.
REQ-007 Parameter V_SYNC, default 2: vertical sync width, in lines.
REQ-008 Parameter V_BACK, default 33: vertical back porch, in lines.
REQ-009 Port clk, input, 1 bit: 25 MHz pixel clock; the only clock.
REQ-010 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-011 Port Din, input, 12 bits: pixel colour {R[11:8], G[7:4], B[3:0]} for the current col/row.
REQ-012 Port col, output, 10 bits: horizontal coordinate of the pixel being requested.
REQ-013 Port row, output, 9 bits: vertical coordinate of the pixel being requested.
REQ-014 Port R, G, B, output, 4 bits each: colour to the DAC.
REQ-015 Port HS, output, 1 bit: horizontal sync, active-low.
REQ-016 Port VS, output, 1 bit: vertical sync, active-low.
REQ-017 Port rdn, output, 1 bit: active-low; low when R/G/B carry a visible pixel.
REQ-018 Port frame_start, output, 1 bit: one-cycle pulse at the start of each frame.
REQ-019 Port vblank, output, 1 bit: high while the line counter is outside the visible lines; used as the snapshot window for display data.

Function
REQ-020 H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (default 800); V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (default 525).
REQ-021 h_cnt (10 bits) shall increment every clk; after H_TOTAL-1 it shall wrap to 0.
REQ-022 v_cnt (10 bits) shall increment only on the h_cnt wrap; after V_TOTAL-1, on an h_cnt wrap, it shall wrap to 0 in the same cycle.
REQ-023 A pixel is visible when h_cnt < H_VISIBLE and v_cnt < V_VISIBLE.
REQ-024 col shall equal h_cnt when h_cnt < H_VISIBLE, else 0.
REQ-025 row shall equal v_cnt[8:0] when v_cnt < V_VISIBLE, else 0.
REQ-026 col and row shall be decoded directly from the counter registers, with no added delay.
REQ-027 Stage 1 register shall capture Din, visible, hs_raw and vs_raw every cycle.
REQ-028 Stage 1 outputs drive {R,G,B}, rdn, HS and VS, giving a fixed 1-cycle latency from col/row to colour.
REQ-029 {R,G,B} shall be Din from the previous cycle if that cycle was visible, else 12'h000.
REQ-030 rdn shall be the inverse of the registered visible flag.
REQ-031 hs_raw = 0 iff H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC (656..751); HS is hs_raw delayed 1 cycle.
REQ-032 vs_raw = 0 iff V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC (490..491); VS is vs_raw delayed 1 cycle.
REQ-033 VS shall change only at line boundaries, aligned with the HS delay.
REQ-034 frame_start shall be a registered pulse, high for exactly the one cycle after counters are at (h=0, v=0).
REQ-035 vblank shall be registered: v_cnt >= V_VISIBLE, delayed 1 cycle.
REQ-036 Din values presented during blanking shall never reach R/G/B.
REQ-037 Counter wrap, HS edge and VS edge occurring in the same cycle shall each be handled independently, with no skipped or doubled line.

Reset
REQ-038 While rst=1: h_cnt=0, v_cnt=0, R=G=B=0, HS=1, VS=1, rdn=1, frame_start=0, vblank=0.
REQ-039 Assertion of rst at any point mid-frame shall force the REQ-038 values immediately, without waiting for a clock edge.
REQ-040 After rst deasserts, counting shall start from (0,0) on the first clk edge, and frame_start shall pulse after that edge.

Verification
REQ-041 Release reset, run one line -> first HS falling edge 657 cycles after release; HS low for 96 cycles; HS period 800 cycles.
REQ-042 Run two frames -> VS low for exactly 1600 cycles beginning at line 490; frame_start pulses exactly 420000 cycles apart; vblank high for 45 lines per frame.
REQ-043 Drive Din=12'hABC while col=0, row=0 -> next cycle R=4'hA, G=4'hB, B=4'hC and rdn=0.
REQ-044 Drive Din=12'hFFF constantly -> R/G/B=0 and rdn=1 on every cycle where the previous counter state had h>=640 or v>=480.
REQ-045 Assert rst asynchronously at h=300, v=200, hold 3 cycles, then release -> REQ-038 values appear before the next clk edge; col=0, row=0 after release; the frame restarts normally.
REQ-046 Check at h=799, v=524 -> next cycle h=0, v=0, col=0, row=0; frame_start is high the following cycle.
